ct_f_spsram_param_shadow: RTL and testbench

//  Parametrised single-port SRAM simulation/FPGA model with true per-bit write mask, configurable

---
 rtl/ct_f_spsram_param_shadow.sv | 161 ++++++++++++++++
 tb/tb_ct_f_spsram_param_shadow.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ct_f_spsram_param_shadow.sv
// Parametrised single-port SRAM model with a per-bit write mask and a
// configurable read latency of 1 or 2 cycles. An optional shadow (taint) array
// carries *_t0 labels through to Q_t0.
// The shadow array is cleared by a sweep after reset. Until that sweep is done,
// reads report fully tainted data.
module ct_f_spsram_param_shadow #(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 14,
    parameter int RD_LAT     = 1,
    parameter int TAINT_EN   = 1
) (
    input  logic                  CLK,
    input  logic                  cpurst_b,
    input  logic [ADDR_WIDTH-1:0] A,
    input  logic [ADDR_WIDTH-1:0] A_t0,
    input  logic                  CEN,
    input  logic                  CEN_t0,
    input  logic                  GWEN,
    input  logic                  GWEN_t0,
    input  logic [DATA_WIDTH-1:0] WEN,
    input  logic [DATA_WIDTH-1:0] WEN_t0,
    input  logic [DATA_WIDTH-1:0] D,
    input  logic [DATA_WIDTH-1:0] D_t0,
    output logic [DATA_WIDTH-1:0] Q,
    output logic [DATA_WIDTH-1:0] Q_t0,
    output logic                  SHADOW_RDY
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] addr_hold_reg;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  rd_en;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] q_s1_reg;
    logic [DATA_WIDTH-1:0] q_t0_s1;

    // When the chip is deselected, the array keeps pointing at the last accessed word.
    assign addr  = CEN ? addr_hold_reg : A;
    assign rd_en = !CEN && GWEN;
    assign wr_en = !CEN && !GWEN;

    // Data array: write only the bits whose active-low mask bit is clear.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            for (int i = 0; i < DATA_WIDTH; i++) begin
                if (!WEN[i]) mem[addr][i] <= D[i];
            end
        end
    end

    // Address hold register and first read-data stage. Q holds its value across writes and idle cycles.
    always_ff @(posedge CLK or negedge cpurst_b) begin
        if (!cpurst_b) begin
            addr_hold_reg <= '0;
            q_s1_reg      <= '0;
        end else begin
            if (!CEN) addr_hold_reg <= A;
            if (rd_en) q_s1_reg <= mem[addr];
        end
    end

    generate
        if (TAINT_EN != 0) begin : g_taint
            typedef enum logic {CLEAR, READY} sweep_state_t;

            sweep_state_t          state_reg, state_next;
            logic [ADDR_WIDTH-1:0] clr_ptr_reg, clr_ptr_next;
            logic [DATA_WIDTH-1:0] shadow_mem [DEPTH];
            logic [DATA_WIDTH-1:0] shadow_rd;
            logic [DATA_WIDTH-1:0] shadow_wdata;
            logic [DATA_WIDTH-1:0] q_t0_s1_reg;
            logic                  ctl_t;

            assign ctl_t     = CEN_t0 | GWEN_t0 | (|A_t0);
            assign shadow_rd = shadow_mem[addr];

            // Bits that are written take fresh labels. Bits that are masked off only accumulate taint.
            for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_bit
                assign shadow_wdata[gi] = WEN[gi]
                    ? (shadow_rd[gi] | WEN_t0[gi] | GWEN_t0 | CEN_t0)
                    : (D_t0[gi] | WEN_t0[gi] | ctl_t);
            end

            // Sweep state and pointer registers.
            always_ff @(posedge CLK or negedge cpurst_b) begin
                if (!cpurst_b) begin
                    state_reg   <= CLEAR;
                    clr_ptr_reg <= '0;
                end else begin
                    state_reg   <= state_next;
                    clr_ptr_reg <= clr_ptr_next;
                end
            end

            // Sweep next-state: step through every word once, then stay in READY.
            always_comb begin
                state_next   = state_reg;
                clr_ptr_next = clr_ptr_reg;
                if (state_reg == CLEAR) begin
                    clr_ptr_next = clr_ptr_reg + ADDR_WIDTH'(1);
                    if (clr_ptr_reg == '1) state_next = READY;
                end
            end

            // Shadow array: sweep clear, with a same-cycle data write to the same word taking priority.
            always_ff @(posedge CLK) begin
                if (state_reg == CLEAR) shadow_mem[clr_ptr_reg] <= '0;
                if (wr_en) shadow_mem[addr] <= shadow_wdata;
            end

            // First taint stage. Before the sweep finishes, reads report all ones.
            // A possibly tainted deselect is also treated as a potential read.
            always_ff @(posedge CLK or negedge cpurst_b) begin
                if (!cpurst_b) begin
                    q_t0_s1_reg <= '0;
                end else if (rd_en) begin
                    q_t0_s1_reg <= ((state_reg == READY) ? shadow_rd : '1) | {DATA_WIDTH{ctl_t}};
                end else if (CEN && CEN_t0) begin
                    q_t0_s1_reg <= '1;
                end
            end

            assign q_t0_s1    = q_t0_s1_reg;
            assign SHADOW_RDY = (state_reg == READY);
        end else begin : g_no_taint
            logic rdy_reg;

            // With no shadow storage there is nothing to sweep, so the block reports ready after the first edge.
            always_ff @(posedge CLK or negedge cpurst_b) begin
                if (!cpurst_b) rdy_reg <= 1'b0;
                else           rdy_reg <= 1'b1;
            end

            assign q_t0_s1    = '0;
            assign SHADOW_RDY = rdy_reg;
        end

        if (RD_LAT == 2) begin : g_lat2
            logic [DATA_WIDTH-1:0] q_s2_reg;
            logic [DATA_WIDTH-1:0] q_t0_s2_reg;

            // Extra output register. Data and taint move through it together.
            always_ff @(posedge CLK or negedge cpurst_b) begin
                if (!cpurst_b) begin
                    q_s2_reg    <= '0;
                    q_t0_s2_reg <= '0;
                end else begin
                    q_s2_reg    <= q_s1_reg;
                    q_t0_s2_reg <= q_t0_s1;
                end
            end

            assign Q    = q_s2_reg;
            assign Q_t0 = q_t0_s2_reg;
        end else begin : g_lat1
            assign Q    = q_s1_reg;
            assign Q_t0 = q_t0_s1;
        end
    endgenerate
endmodule

// File: tb/tb_ct_f_spsram_param_shadow.sv
// Randomised self-checking bench. Three instances share the same stimulus:
// taint with RD_LAT=1, taint with RD_LAT=2, and no taint with RD_LAT=1.
// They are checked against an abstract model of the memory contents and labels.
module tb_ct_f_spsram_param_shadow;
    localparam int DW = 128;
    localparam int AW = 4;
    localparam int DEPTH = 16;

    logic          CLK = 1'b0;
    logic          cpurst_b = 1'b1;
    logic [AW-1:0] A, A_t0;
    logic          CEN, CEN_t0, GWEN, GWEN_t0;
    logic [DW-1:0] WEN, WEN_t0, D, D_t0;
    logic [DW-1:0] q1, qt1, q2, qt2, qn, qtn;
    logic          rdy1, rdy2, rdyn;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [DW-1:0] mem_m [DEPTH];
    bit            memk [DEPTH];
    logic [DW-1:0] sh_m [DEPTH];
    int            sweep_cnt;
    bit            nt_rdy;
    logic [DW-1:0] e_q1, e_qt1, e_q2, e_qt2;
    bit            e_q1k, e_q2k;

    always #5 CLK = ~CLK;

    ct_f_spsram_param_shadow #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LAT(1), .TAINT_EN(1)) dut1 (
        .CLK(CLK), .cpurst_b(cpurst_b), .A(A), .A_t0(A_t0), .CEN(CEN), .CEN_t0(CEN_t0),
        .GWEN(GWEN), .GWEN_t0(GWEN_t0), .WEN(WEN), .WEN_t0(WEN_t0), .D(D), .D_t0(D_t0),
        .Q(q1), .Q_t0(qt1), .SHADOW_RDY(rdy1));
    ct_f_spsram_param_shadow #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LAT(2), .TAINT_EN(1)) dut2 (
        .CLK(CLK), .cpurst_b(cpurst_b), .A(A), .A_t0(A_t0), .CEN(CEN), .CEN_t0(CEN_t0),
        .GWEN(GWEN), .GWEN_t0(GWEN_t0), .WEN(WEN), .WEN_t0(WEN_t0), .D(D), .D_t0(D_t0),
        .Q(q2), .Q_t0(qt2), .SHADOW_RDY(rdy2));
    ct_f_spsram_param_shadow #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LAT(1), .TAINT_EN(0)) dutn (
        .CLK(CLK), .cpurst_b(cpurst_b), .A(A), .A_t0(A_t0), .CEN(CEN), .CEN_t0(CEN_t0),
        .GWEN(GWEN), .GWEN_t0(GWEN_t0), .WEN(WEN), .WEN_t0(WEN_t0), .D(D), .D_t0(D_t0),
        .Q(qn), .Q_t0(qtn), .SHADOW_RDY(rdyn));

    function automatic logic [DW-1:0] rand_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_reset();
        sweep_cnt = 0;
        nt_rdy = 0;
        e_q1 = '0; e_qt1 = '0; e_q2 = '0; e_qt2 = '0;
        e_q1k = 1; e_q2k = 1;
    endtask

    // Drive one cycle, wait for the edge, update the model, then settle 1 time unit.
    task automatic drive(input logic cen, input logic gwen, input logic [AW-1:0] a,
                         input logic [DW-1:0] wen, input logic [DW-1:0] d,
                         input logic cen_t0, input logic gwen_t0, input logic [AW-1:0] a_t0,
                         input logic [DW-1:0] wen_t0, input logic [DW-1:0] d_t0);
        logic ctl;
        bit   was_rdy;
        CEN = cen; GWEN = gwen; A = a; WEN = wen; D = d;
        CEN_t0 = cen_t0; GWEN_t0 = gwen_t0; A_t0 = a_t0; WEN_t0 = wen_t0; D_t0 = d_t0;
        @(posedge CLK);
        ctl = cen_t0 | gwen_t0 | (|a_t0);
        was_rdy = (sweep_cnt >= DEPTH);
        e_q2 = e_q1; e_q2k = e_q1k; e_qt2 = e_qt1;
        nt_rdy = 1;
        if (!was_rdy) begin
            sh_m[sweep_cnt] = '0;
            sweep_cnt++;
        end
        if (!cen) begin
            if (!gwen) begin
                for (int i = 0; i < DW; i++) begin
                    if (!wen[i]) begin
                        mem_m[a][i] = d[i];
                        sh_m[a][i] = d_t0[i] | wen_t0[i] | ctl;
                    end else begin
                        sh_m[a][i] = sh_m[a][i] | wen_t0[i] | gwen_t0 | cen_t0;
                    end
                end
                if (wen == '0) memk[a] = 1;
            end else begin
                e_q1 = mem_m[a];
                e_q1k = memk[a];
                e_qt1 = was_rdy ? (sh_m[a] | {DW{ctl}}) : '1;
            end
        end else if (cen_t0) begin
            e_qt1 = '1;
        end
        #1;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW-1:0] wen);
        drive(1'b0, 1'b0, a, wen, d, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [AW-1:0] a_t0);
        drive(1'b0, 1'b1, a, '1, '0, 1'b0, 1'b0, a_t0, '0, '0);
    endtask

    task automatic do_idle(input logic cen_t0, input logic [AW-1:0] a);
        drive(1'b1, 1'b1, a, '1, '0, cen_t0, 1'b0, '0, '0, '0);
    endtask

    task automatic test_reset();
        CEN = 1; GWEN = 1; A = '0; WEN = '1; D = '0;
        CEN_t0 = 0; GWEN_t0 = 0; A_t0 = '0; WEN_t0 = '0; D_t0 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            memk[i] = 0; sh_m[i] = '1; mem_m[i] = '0;
        end
        #2 cpurst_b = 0;
        model_reset();
        repeat (3) @(posedge CLK);
        #1;
        checks++; if (q1 !== '0)   begin errors++; $display("FAIL reset_q got %h exp 0", q1); end
        checks++; if (qt1 !== '0)  begin errors++; $display("FAIL reset_qt got %h exp 0", qt1); end
        checks++; if (rdy1 !== 0)  begin errors++; $display("FAIL reset_rdy got %b exp 0", rdy1); end
        checks++; if (q2 !== '0)   begin errors++; $display("FAIL reset_q2 got %h exp 0", q2); end
        checks++; if (rdyn !== 0)  begin errors++; $display("FAIL reset_nt_rdy got %b exp 0", rdyn); end
        cpurst_b = 1;
        for (int k = 1; k <= 17; k++) begin
            do_read(AW'($urandom_range(0, DEPTH - 1)), '0);
            $display("sweep edge %0d: rdy=%b qt1=%h", k, rdy1, qt1);
            checks++; if (rdy1 !== (k >= 16)) begin errors++; $display("FAIL sweep_rdy edge %0d got %b exp %b", k, rdy1, (k >= 16)); end
            checks++; if (qt1 !== e_qt1) begin errors++; $display("FAIL sweep_qt edge %0d got %h exp %h", k, qt1, e_qt1); end
            checks++; if (qt2 !== e_qt2) begin errors++; $display("FAIL sweep_qt2 edge %0d got %h exp %h", k, qt2, e_qt2); end
            checks++; if (rdyn !== 1'b1 || qtn !== '0) begin errors++; $display("FAIL nt_ready edge %0d got rdy=%b qt=%h exp rdy=1 qt=0", k, rdyn, qtn); end
        end
        for (int i = 0; i < DEPTH; i++) do_write(AW'(i), rand_word(), '0);
    endtask

    task automatic test_basic();
        logic [DW-1:0] pat;
        pat = {16{8'hA5}};
        do_write(4'd5, pat, '0);
        do_read(4'd5, '0);
        $display("read addr 5: q1=%h qt1=%h", q1, qt1);
        checks++; if (q1 !== pat || qt1 !== '0) begin errors++; $display("FAIL basic_lat1 got %h/%h exp %h/0", q1, qt1, pat); end
        checks++; if (q2 !== e_q2) begin errors++; $display("FAIL basic_lat2_early got %h exp %h", q2, e_q2); end
        do_idle(1'b0, 4'd9);
        $display("one more edge: q2=%h qt2=%h", q2, qt2);
        checks++; if (q2 !== pat || qt2 !== '0) begin errors++; $display("FAIL basic_lat2 got %h/%h exp %h/0", q2, qt2, pat); end
        checks++; if (qn !== pat) begin errors++; $display("FAIL basic_nt got %h exp %h", qn, pat); end
        do_write(4'd5, '0, '0);
        checks++; if (q1 !== pat) begin errors++; $display("FAIL no_write_through got %h exp %h", q1, pat); end
        do_read(4'd5, '0);
        checks++; if (q1 !== '0) begin errors++; $display("FAIL write_then_read got %h exp 0", q1); end
    endtask

    task automatic test_mask();
        logic [DW-1:0] exp;
        exp = DW'(8'hFF);
        do_write(4'd3, '0, '0);
        do_write(4'd3, '1, {{(DW-8){1'b1}}, 8'h00});
        do_read(4'd3, '0);
        $display("mask write addr 3: q1=%h", q1);
        checks++; if (q1 !== exp) begin errors++; $display("FAIL mask got %h exp %h", q1, exp); end
    endtask

    task automatic test_taint();
        drive(1'b0, 1'b0, 4'd7, '0, rand_word(), 1'b0, 1'b0, '0, '0, DW'(1));
        do_read(4'd7, '0);
        $display("taint read addr 7: qt1=%h", qt1);
        checks++; if (qt1 !== DW'(1)) begin errors++; $display("FAIL taint_d got %h exp 1", qt1); end
        do_read(4'd7, 4'h2);
        checks++; if (qt1 !== '1) begin errors++; $display("FAIL taint_addr got %h exp all ones", qt1); end
        checks++; if (qt2 !== DW'(1)) begin errors++; $display("FAIL taint_d_lat2 got %h exp 1", qt2); end
    endtask

    task automatic test_idle();
        logic [DW-1:0] held;
        do_read(4'd5, '0);
        held = e_q1;
        do_idle(1'b1, 4'd2);
        $display("idle cen_t0=1: q1=%h qt1=%h", q1, qt1);
        checks++; if (q1 !== held || qt1 !== '1) begin errors++; $display("FAIL idle_t0 got %h/%h exp %h/ones", q1, qt1, held); end
        do_idle(1'b0, 4'd4);
        checks++; if (q1 !== held || qt1 !== '1) begin errors++; $display("FAIL idle_hold got %h/%h exp %h/ones", q1, qt1, held); end
        checks++; if (qt2 !== '1) begin errors++; $display("FAIL idle_t0_lat2 got %h exp ones", qt2); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            logic          cen, gwen, cen_t0, gwen_t0;
            logic [AW-1:0] a, a_t0;
            logic [DW-1:0] wen, wen_t0, d_t0;
            int            sel;
            cen = ($urandom_range(0, 3) == 0);
            gwen = $urandom_range(0, 1);
            a = AW'($urandom_range(0, DEPTH - 1));
            sel = $urandom_range(0, 2);
            wen = (sel == 0) ? '0 : (sel == 1) ? rand_word() : '1;
            cen_t0 = ($urandom_range(0, 9) == 0);
            gwen_t0 = ($urandom_range(0, 9) == 0);
            a_t0 = ($urandom_range(0, 9) == 0) ? AW'($urandom_range(1, DEPTH - 1)) : '0;
            wen_t0 = ($urandom_range(0, 7) == 0) ? (rand_word() & rand_word() & rand_word()) : '0;
            d_t0 = ($urandom_range(0, 3) == 0) ? (rand_word() & rand_word()) : '0;
            drive(cen, gwen, a, wen, rand_word(), cen_t0, gwen_t0, a_t0, wen_t0, d_t0);
            $display("rand %0d cen=%b gwen=%b a=%0d q1=%h qt1=%h", n, cen, gwen, a, q1, qt1);
            if (e_q1k) begin
                checks++; if (q1 !== e_q1) begin errors++; $display("FAIL rand_q1 %0d got %h exp %h", n, q1, e_q1); end
                checks++; if (qn !== e_q1) begin errors++; $display("FAIL rand_qn %0d got %h exp %h", n, qn, e_q1); end
            end
            if (e_q2k) begin
                checks++; if (q2 !== e_q2) begin errors++; $display("FAIL rand_q2 %0d got %h exp %h", n, q2, e_q2); end
            end
            checks++; if (qt1 !== e_qt1) begin errors++; $display("FAIL rand_qt1 %0d got %h exp %h", n, qt1, e_qt1); end
            checks++; if (qt2 !== e_qt2) begin errors++; $display("FAIL rand_qt2 %0d got %h exp %h", n, qt2, e_qt2); end
            checks++; if (qtn !== '0) begin errors++; $display("FAIL rand_qtn %0d got %h exp 0", n, qtn); end
        end
    endtask

    task automatic test_mid_reset();
        logic [DW-1:0] marker;
        marker = {32{4'hC}};
        do_write(4'd1, marker, '0);
        CEN = 1;
        cpurst_b = 0; #1; model_reset();
        @(posedge CLK); #1;
        cpurst_b = 1;
        for (int k = 1; k <= 9; k++) do_read(4'd1, '0);
        checks++; if (q1 !== marker) begin errors++; $display("FAIL mid_read got %h exp %h", q1, marker); end
        CEN = 1;
        cpurst_b = 0; #1; model_reset();
        $display("reset mid-sweep: q1=%h rdy=%b", q1, rdy1);
        checks++; if (q1 !== '0 || qt1 !== '0) begin errors++; $display("FAIL mid_reset_q got %h/%h exp 0/0", q1, qt1); end
        checks++; if (rdy1 !== 0 || rdy2 !== 0) begin errors++; $display("FAIL mid_reset_rdy got %b exp 0", rdy1); end
        @(posedge CLK); #1;
        cpurst_b = 1;
        for (int k = 1; k <= 16; k++) begin
            do_idle(1'b0, '0);
            checks++; if (rdy1 !== (k >= 16)) begin errors++; $display("FAIL resweep_rdy edge %0d got %b exp %b", k, rdy1, (k >= 16)); end
        end
        do_read(4'd1, '0);
        $display("after resweep read addr 1: q1=%h qt1=%h", q1, qt1);
        checks++; if (q1 !== marker || qt1 !== '0) begin errors++; $display("FAIL resweep_read got %h/%h exp %h/0", q1, qt1, marker); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_mask();
        test_taint();
        test_idle();
        test_random();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
